// File: rtl/test_pattern_generator_if.sv
// Video timing bundle shared by the upstream timing generator and the pattern source output:
// data enable, syncs, HDMI control flags and active-area pixel position.
interface test_pattern_generator_if #(
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 11
);
  logic               videoDataEnable;
  logic               hSync;
  logic               vSync;
  logic               activeVideoPreamble;
  logic               activeVideoGuardBand;
  logic [H_WIDTH-1:0] hPos;
  logic [V_WIDTH-1:0] vPos;

  modport master (
    output videoDataEnable, hSync, vSync, activeVideoPreamble, activeVideoGuardBand, hPos, vPos
  );

  modport slave (
    input videoDataEnable, hSync, vSync, activeVideoPreamble, activeVideoGuardBand, hPos, vPos
  );
endinterface

// File: rtl/test_pattern_generator.sv
// Multi-mode video test pattern source with a fixed three-stage pixel pipeline and
// frame-synchronous mode switching; timing signals are delayed to stay aligned with the pixels.
module test_pattern_generator #(
  parameter int COLOR_WIDTH = 8,
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 11
) (
  input  logic                   pixelClock,
  input  logic                   reset,
  input  logic                   pixelEnable,
  test_pattern_generator_if.slave  videoIn,
  test_pattern_generator_if.master videoOut,
  input  logic [H_WIDTH-1:0]     hActive,
  input  logic [V_WIDTH-1:0]     vActive,
  input  logic [2:0]             modeIn,
  input  logic                   modeLoad,
  input  logic [H_WIDTH-1:0]     barWidth,
  input  logic [3:0]             checkerShift,
  input  logic [COLOR_WIDTH-1:0] scrollStep,
  input  logic [COLOR_WIDTH-1:0] solidRed,
  input  logic [COLOR_WIDTH-1:0] solidGreen,
  input  logic [COLOR_WIDTH-1:0] solidBlue,
  output logic [COLOR_WIDTH-1:0] red,
  output logic [COLOR_WIDTH-1:0] green,
  output logic [COLOR_WIDTH-1:0] blue,
  output logic [2:0]             activeMode,
  output logic [15:0]            frameCount
);

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_RAMP     = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_CHECKER  = 3'd4,
    MODE_BORDER   = 3'd5
  } PatternMode;

  localparam logic [COLOR_WIDTH-1:0] FULL  = '1;
  localparam logic [H_WIDTH-1:0]     H_ONE = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0]     V_ONE = V_WIDTH'(1);

  logic                   vSyncPrev;
  logic                   vSyncRise;
  logic [2:0]             pendingMode;
  logic [2:0]             nextMode;
  logic [COLOR_WIDTH-1:0] rampOffset;
  logic [COLOR_WIDTH-1:0] nextRamp;
  logic [H_WIDTH-1:0]     barPixel;
  logic [2:0]             barIndex;

  logic                   s1De, s1HSync, s1VSync, s1Preamble, s1GuardBand;
  logic [H_WIDTH-1:0]     s1HPos;
  logic [V_WIDTH-1:0]     s1VPos;
  logic [2:0]             s1Mode;
  logic [COLOR_WIDTH-1:0] s1Ramp;
  logic [2:0]             s1BarIndex;

  logic                   s2De, s2HSync, s2VSync, s2Preamble, s2GuardBand;
  logic [H_WIDTH-1:0]     s2HPos;
  logic [V_WIDTH-1:0]     s2VPos;
  logic [COLOR_WIDTH-1:0] s2Red, s2Green, s2Blue;

  logic [COLOR_WIDTH-1:0] patRed, patGreen, patBlue;
  logic [H_WIDTH-1:0]     hShifted;
  logic [V_WIDTH-1:0]     vShifted;

  // A load coinciding with the vSync edge bypasses the pending register.
  always_comb begin
    vSyncRise = videoIn.vSync & ~vSyncPrev;
    nextMode  = modeLoad ? modeIn : pendingMode;
    nextRamp  = rampOffset + scrollStep;
  end

  always_ff @(posedge pixelClock) begin
    if (!reset) begin
      vSyncPrev   <= 1'b0;
      pendingMode <= '0;
      activeMode  <= '0;
      rampOffset  <= '0;
      frameCount  <= '0;
      barPixel    <= '0;
      barIndex    <= '0;
      s1De        <= 1'b0;
      s1HSync     <= 1'b0;
      s1VSync     <= 1'b0;
      s1Preamble  <= 1'b0;
      s1GuardBand <= 1'b0;
      s1HPos      <= '0;
      s1VPos      <= '0;
      s1Mode      <= '0;
      s1Ramp      <= '0;
      s1BarIndex  <= '0;
    end else if (pixelEnable) begin
      vSyncPrev   <= videoIn.vSync;
      s1De        <= videoIn.videoDataEnable;
      s1HSync     <= videoIn.hSync;
      s1VSync     <= videoIn.vSync;
      s1Preamble  <= videoIn.activeVideoPreamble;
      s1GuardBand <= videoIn.activeVideoGuardBand;
      s1HPos      <= videoIn.hPos;
      s1VPos      <= videoIn.vPos;
      if (modeLoad) begin
        pendingMode <= modeIn;
      end
      // Each pixel carries the mode and ramp offset in force when it was sampled.
      s1Mode <= vSyncRise ? nextMode : activeMode;
      s1Ramp <= vSyncRise ? nextRamp : rampOffset;
      if (vSyncRise) begin
        activeMode <= nextMode;
        rampOffset <= nextRamp;
        frameCount <= frameCount + 16'd1;
      end
      s1BarIndex <= videoIn.videoDataEnable ? barIndex : '0;
      if (!videoIn.videoDataEnable || barWidth == '0) begin
        barPixel <= '0;
        barIndex <= '0;
      end else if (barPixel == barWidth - H_ONE) begin
        barPixel <= '0;
        if (barIndex != 3'd7) begin
          barIndex <= barIndex + 3'd1;
        end
      end else begin
        barPixel <= barPixel + H_ONE;
      end
    end
  end

  // Shifting past the vector width yields zero, so oversized checker cells read bit value 0.
  always_comb begin
    patRed   = '0;
    patGreen = '0;
    patBlue  = '0;
    hShifted = s1HPos >> checkerShift;
    vShifted = s1VPos >> checkerShift;
    case (s1Mode)
      MODE_SOLID: begin
        patRed   = solidRed;
        patGreen = solidGreen;
        patBlue  = solidBlue;
      end
      MODE_BARS: begin
        patRed   = s1BarIndex[1] ? '0 : FULL;
        patGreen = s1BarIndex[2] ? '0 : FULL;
        patBlue  = s1BarIndex[0] ? '0 : FULL;
      end
      MODE_RAMP: begin
        patRed   = s1HPos[COLOR_WIDTH-1:0] + s1Ramp;
        patGreen = patRed;
        patBlue  = patRed;
      end
      MODE_GRADIENT: begin
        patRed   = s1VPos[COLOR_WIDTH-1:0];
        patGreen = s1HPos[COLOR_WIDTH-1:0];
        patBlue  = patRed ^ patGreen;
      end
      MODE_CHECKER: begin
        if ((|(hShifted & H_ONE)) ^ (|(vShifted & V_ONE))) begin
          patRed   = FULL;
          patGreen = FULL;
          patBlue  = FULL;
        end
      end
      MODE_BORDER: begin
        if (s1HPos == '0 || s1HPos == hActive - H_ONE ||
            s1VPos == '0 || s1VPos == vActive - V_ONE) begin
          patRed   = FULL;
          patGreen = FULL;
          patBlue  = FULL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixelClock) begin
    if (!reset) begin
      s2De        <= 1'b0;
      s2HSync     <= 1'b0;
      s2VSync     <= 1'b0;
      s2Preamble  <= 1'b0;
      s2GuardBand <= 1'b0;
      s2HPos      <= '0;
      s2VPos      <= '0;
      s2Red       <= '0;
      s2Green     <= '0;
      s2Blue      <= '0;
    end else if (pixelEnable) begin
      s2De        <= s1De;
      s2HSync     <= s1HSync;
      s2VSync     <= s1VSync;
      s2Preamble  <= s1Preamble;
      s2GuardBand <= s1GuardBand;
      s2HPos      <= s1HPos;
      s2VPos      <= s1VPos;
      s2Red       <= patRed;
      s2Green     <= patGreen;
      s2Blue      <= patBlue;
    end
  end

  // Output stage blanks colour outside the active area.
  always_ff @(posedge pixelClock) begin
    if (!reset) begin
      videoOut.videoDataEnable      <= 1'b0;
      videoOut.hSync                <= 1'b0;
      videoOut.vSync                <= 1'b0;
      videoOut.activeVideoPreamble  <= 1'b0;
      videoOut.activeVideoGuardBand <= 1'b0;
      videoOut.hPos                 <= '0;
      videoOut.vPos                 <= '0;
      red                           <= '0;
      green                         <= '0;
      blue                          <= '0;
    end else if (pixelEnable) begin
      videoOut.videoDataEnable      <= s2De;
      videoOut.hSync                <= s2HSync;
      videoOut.vSync                <= s2VSync;
      videoOut.activeVideoPreamble  <= s2Preamble;
      videoOut.activeVideoGuardBand <= s2GuardBand;
      videoOut.hPos                 <= s2HPos;
      videoOut.vPos                 <= s2VPos;
      red                           <= s2De ? s2Red : '0;
      green                         <= s2De ? s2Green : '0;
      blue                          <= s2De ? s2Blue : '0;
    end
  end

endmodule

// File: doc/test_pattern_generator.md
# test_pattern_generator

Parametrised multi-mode video test pattern source for the HDMI/DVI path. It sits between the video format timing generator and the text overlay (or HDMI encoder), and produces RGB at a configurable colour depth. Patterns: solid colour, 8-bar colour bars, scrolling grayscale ramp, 2-D gradient, checkerboard and frame border. Mode changes are frame-synchronous, and every timing signal is delayed to match the fixed pixel pipeline.

## Interface
- COLOR_WIDTH, 8, bits per colour component; must be ≤ H_WIDTH and ≤ V_WIDTH
- H_WIDTH, 12, width of horizontal position and size inputs
- V_WIDTH, 11, width of vertical position and size inputs
---
- pixelClock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- pixelEnable  in  1  advances pipeline, counters and edge detector; 0 freezes all state
- videoDataEnableIn, hSyncIn, vSyncIn, activeVideoPreambleIn, activeVideoGuardBandIn  in  1 each  upstream timing; vSyncIn is active-high
- hPosIn / vPosIn  in  H_WIDTH / V_WIDTH  active-area pixel position, (0,0) = top-left
- hActive / vActive  in  H_WIDTH / V_WIDTH  active width/height (border mode)
- modeIn  in  3  requested mode
- modeLoad  in  1  strobe; captures modeIn into pending register
- barWidth  in  H_WIDTH  pixels per colour bar
- checkerShift  in  4  checker cell size = 2^checkerShift
- scrollStep  in  COLOR_WIDTH  ramp offset added per frame
- solidRed / solidGreen / solidBlue  in  COLOR_WIDTH each  solid-mode colour
- videoDataEnableOut, hSyncOut, vSyncOut, activeVideoPreambleOut, activeVideoGuardBandOut  out  1 each  inputs delayed 3 enabled cycles
- hPosOut / vPosOut  out  H_WIDTH / V_WIDTH  positions delayed 3 enabled cycles
- red / green / blue  out  COLOR_WIDTH each  pattern pixel
- activeMode  out  3  mode currently being rendered
- frameCount  out  16  vSync rising edges since reset; wraps modulo 2^16

## Operation
- Mode path:
  - modeLoad=1 writes modeIn into pendingMode.
  - On each vSync rising edge (vSyncIn=1 while previous enabled sample was 0), activeMode ← pendingMode.
  - If modeLoad coincides with that edge, the new modeIn goes straight to activeMode.
- Frame state on each vSync rising edge:
  - frameCount += 1.
  - rampOffset += scrollStep, modulo 2^COLOR_WIDTH.
- Bar counter, stage 1, counts only enabled cycles:
  - videoDataEnableIn=0 clears barPixel and barIndex.
  - Otherwise barPixel increments. When barPixel = barWidth−1, barPixel ← 0 and barIndex increments, saturating at 7.
  - barWidth=0 holds barIndex at 0.
- Modes (M = all-ones):
  - 0 solid: solidRed/Green/Blue.
  - 1 bars: R = M if barIndex[1]=0; G = M if barIndex[2]=0; B = M if barIndex[0]=0. Sequence is white, yellow, cyan, green, magenta, red, blue, black.
  - 2 ramp: R = G = B = (hPos + rampOffset)[COLOR_WIDTH-1:0].
  - 3 gradient: R = vPos[COLOR_WIDTH-1:0], G = hPos[COLOR_WIDTH-1:0], B = R XOR G.
  - 4 checker: M,M,M when hPos[checkerShift] XOR vPos[checkerShift] = 1, else 0. A shift ≥ width uses bit value 0.
  - 5 border: M,M,M when hPos=0, hPos=hActive−1, vPos=0 or vPos=vActive−1; else 0.
  - 6, 7: black.
- Blanking: red/green/blue = 0 whenever delayed data enable = 0.
- Reset (reset=0 on a clock edge):
  - All outputs, pipeline registers, pendingMode, activeMode, frameCount, rampOffset, bar counter and vSync history go to 0.
  - Reset overrides pixelEnable and aborts the in-flight frame.

## Timing
- Pipeline: stage 1 registers inputs and updates the bar counter; stage 2 computes the pattern; stage 3 blanks and registers outputs.
- Latency is exactly 3 enabled cycles for pixels and all timing/position outputs, which stay mutually aligned.
- pixelEnable=0 holds every register, including counters and the vSync edge detector; no sample is lost or duplicated.
- activeMode and rampOffset update in the stage-1 cycle of the edge. Pixels sampled at or after the edge use the new values; pixels already in the pipeline keep the values they captured.
- rampOffset wraps silently. barIndex saturates and never wraps within a line.

## Test plan
- Reset: hold reset=0 for 4 cycles with random inputs → all outputs 0, activeMode=0, frameCount=0. Release → first valid pixel appears 3 cycles after the first data-enabled input.
- Bars: mode 1, barWidth=160, 1280-pixel line → output pixels 0–159 = (FF,FF,FF), 160 = (FF,FF,00), 1119 = (00,00,FF), 1120–1279 = (00,00,00). Blanked pixels = 0.
- Deferred mode: modeLoad with modeIn=3 mid-frame → activeMode and pixels unchanged until the next vSync rising edge. The first active pixel after it, at (0,0), is (00,00,00).
- Scroll: mode 2, scrollStep=4 → after 3 vSync edges pixel hPos=10 = 0x16. After 64 edges rampOffset wraps to 0.
- Stall: mode 3, toggle pixelEnable pseudo-randomly → output stream equals the unstalled stream with held values during stalls; timing outputs stay aligned.
- Border and mid-frame reset: mode 5, hActive=1280, vActive=720 → pixels at hPos 0/1279 and vPos 0/719 are white, interior black. reset=0 at line 300 → outputs 0 next cycle and activeMode=0 after release.
